// File: rtl/mdu_if.sv
// Pipeline <-> multiply/divide unit bundle: operands, op code and handshake in,
// HI/LO architectural registers and the stall indication out.
interface mdu_if;
    logic [31:0] A;
    logic [31:0] B;
    logic [2:0]  MDUOp;
    logic        Start;
    logic        Flush;
    logic        Busy;
    logic [31:0] HI;
    logic [31:0] LO;

    modport master (output A, B, MDUOp, Start, Flush, input Busy, HI, LO);
    modport slave  (input A, B, MDUOp, Start, Flush, output Busy, HI, LO);
endinterface

// File: rtl/mdu_iter.sv
// Multi-cycle MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Multiply completes one cycle after Start; divide is restoring, one quotient bit per cycle.
module mdu_iter #(
    parameter int DIV_CYCLES = 32
) (
    input logic  clk,
    input logic  rst,
    mdu_if.slave bus
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] MUL  = 2'd1;
    localparam logic [1:0] DIV  = 2'd2;
    localparam logic [1:0] FIX  = 2'd3;

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;

    localparam logic [5:0] LAST_ITER = 6'(DIV_CYCLES - 1);

    logic [1:0]  state;
    logic [63:0] prod;
    logic [31:0] rem, quot, dvsr, a_sav;
    logic [31:0] hi_q, lo_q;
    logic [5:0]  cnt;
    logic        sign_a, sign_b, dz;

    // Even op codes within each pair are the signed variants.
    logic        op_signed, sa, sb;
    logic [31:0] abs_a, abs_b;
    logic [63:0] ext_a, ext_b, prod_next;
    logic [32:0] trial, diff;
    logic        ge;
    logic [31:0] q_fix, r_fix;

    always_comb begin
        op_signed = ~bus.MDUOp[0];
        sa        = op_signed & bus.A[31];
        sb        = op_signed & bus.B[31];
        abs_a     = sa ? -bus.A : bus.A;
        abs_b     = sb ? -bus.B : bus.B;
        ext_a     = {{32{sa}}, bus.A};
        ext_b     = {{32{sb}}, bus.B};
        prod_next = ext_a * ext_b;
    end

    // Remainder stays below the divisor, so the borrow bit alone decides the quotient bit.
    always_comb begin
        trial = {rem, quot[31]};
        diff  = trial - {1'b0, dvsr};
        ge    = ~diff[32];
        q_fix = (sign_a ^ sign_b) ? -quot : quot;
        r_fix = sign_a ? -rem : rem;
    end

    assign bus.Busy = (state != IDLE);
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            prod   <= '0;
            rem    <= '0;
            quot   <= '0;
            dvsr   <= '0;
            a_sav  <= '0;
            cnt    <= '0;
            sign_a <= 1'b0;
            sign_b <= 1'b0;
            dz     <= 1'b0;
            hi_q   <= '0;
            lo_q   <= '0;
        end else if (bus.Flush) begin
            state <= IDLE;
        end else begin
            case (state)
                IDLE: if (bus.Start) begin
                    case (bus.MDUOp)
                        OP_MULT, OP_MULTU: begin
                            prod  <= prod_next;
                            state <= MUL;
                        end
                        OP_DIV, OP_DIVU: begin
                            rem    <= '0;
                            quot   <= abs_a;
                            dvsr   <= abs_b;
                            sign_a <= sa;
                            sign_b <= sb;
                            dz     <= (bus.B == 32'd0);
                            a_sav  <= bus.A;
                            cnt    <= '0;
                            state  <= DIV;
                        end
                        OP_MTHI: hi_q <= bus.A;
                        OP_MTLO: lo_q <= bus.A;
                        default: ;
                    endcase
                end
                MUL: begin
                    hi_q  <= prod[63:32];
                    lo_q  <= prod[31:0];
                    state <= IDLE;
                end
                DIV: begin
                    rem  <= ge ? diff[31:0] : trial[31:0];
                    quot <= {quot[30:0], ge};
                    cnt  <= cnt + 6'd1;
                    if (cnt == LAST_ITER) state <= FIX;
                end
                FIX: begin
                    // Divide by zero bypasses sign fixup entirely.
                    lo_q  <= dz ? 32'hFFFF_FFFF : q_fix;
                    hi_q  <= dz ? a_sav : r_fix;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: directed and random ops against an arithmetic reference model,
// plus flush, busy-start, undefined-op and asynchronous reset scenarios.
module tb_mdu_iter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int checks = 0;
    int failures = 0;

    mdu_if bus ();
    mdu_iter dut (.clk(clk), .rst(rst), .bus(bus.slave));

    always #5 clk = ~clk;

    // {HI, LO} expected from the architectural definition of each op.
    function automatic logic [63:0] ref_mdu(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint p;
        logic [63:0] pu;
        int sa, sb;
        sa = a;
        sb = b;
        case (op)
            3'b000: begin p = longint'(sa) * longint'(sb); return p; end
            3'b001: begin pu = {32'd0, a} * {32'd0, b}; return pu; end
            3'b010: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                return {32'(sa % sb), 32'(sa / sb)};
            end
            default: begin
                if (b == 0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
        endcase
    endfunction

    task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.MDUOp = op; bus.A = a; bus.B = b; bus.Start = 1'b1;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        // operands must have been captured already
        bus.A = $urandom; bus.B = $urandom;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        while (bus.Busy === 1'b1 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    task automatic run_op(input string name, input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] exp;
        int n, exp_n;
        exp = ref_mdu(op, a, b);
        exp_n = (op[1] == 1'b0) ? 1 : 33;
        issue(op, a, b);
        wait_idle(n);
        checks++;
        if (n !== exp_n) begin failures++; $display("FAIL %s busy_cycles got=%0d exp=%0d", name, n, exp_n); end
        checks++;
        if (bus.HI !== exp[63:32]) begin failures++; $display("FAIL %s HI op=%0d a=%h b=%h got=%h exp=%h", name, op, a, b, bus.HI, exp[63:32]); end
        checks++;
        if (bus.LO !== exp[31:0]) begin failures++; $display("FAIL %s LO op=%0d a=%h b=%h got=%h exp=%h", name, op, a, b, bus.LO, exp[31:0]); end
    endtask

    task automatic check_hl(input string name, input logic busy_e, input logic [31:0] hi_e, input logic [31:0] lo_e);
        checks++;
        if (bus.Busy !== busy_e) begin failures++; $display("FAIL %s Busy got=%b exp=%b", name, bus.Busy, busy_e); end
        checks++;
        if (bus.HI !== hi_e) begin failures++; $display("FAIL %s HI got=%h exp=%h", name, bus.HI, hi_e); end
        checks++;
        if (bus.LO !== lo_e) begin failures++; $display("FAIL %s LO got=%h exp=%h", name, bus.LO, lo_e); end
    endtask

    task automatic test_reset();
        bus.A = '0; bus.B = '0; bus.MDUOp = 3'b111; bus.Start = 1'b0; bus.Flush = 1'b0;
        rst = 1'b1;
        #12;
        check_hl("reset", 1'b0, 32'd0, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_mult();
        run_op("multu_max", 3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        run_op("mult_neg3x7", 3'b000, 32'hFFFF_FFFD, 32'd7);
        run_op("mult_minxmin", 3'b000, 32'h8000_0000, 32'h8000_0000);
        for (int i = 0; i < 20; i++)
            run_op("mult_rand", 3'(i & 1), $urandom, $urandom);
    endtask

    task automatic test_div();
        run_op("div_neg7_2", 3'b010, 32'hFFFF_FFF9, 32'd2);
        run_op("divu_100_7", 3'b011, 32'd100, 32'd7);
        run_op("div_ovf", 3'b010, 32'h8000_0000, 32'hFFFF_FFFF);
        run_op("div_7_neg2", 3'b010, 32'd7, 32'hFFFF_FFFE);
        run_op("divu_big", 3'b011, 32'hFFFF_FFFF, 32'd1);
        for (int i = 0; i < 12; i++) begin
            logic [31:0] b;
            b = (i % 3 == 0) ? 32'($urandom_range(1, 20)) : $urandom;
            if (i % 2 == 0) b = -b;
            run_op("div_rand", {2'b01, 1'(i % 2)}, $urandom, b);
        end
    endtask

    task automatic test_div_zero();
        run_op("div_zero", 3'b010, 32'h1234_5678, 32'd0);
        run_op("divu_zero", 3'b011, 32'h8765_4321, 32'd0);
        run_op("div_zero_neg", 3'b010, 32'hFFFF_FFF0, 32'd0);
    endtask

    task automatic test_mthi_mtlo();
        logic [31:0] h, l;
        h = $urandom; l = $urandom;
        issue(3'b100, h, 32'd0);
        issue(3'b101, l, 32'd0);
        check_hl("mthi_mtlo", 1'b0, h, l);
        issue(3'b110, 32'hDEAD_BEEF, 32'd1);
        issue(3'b111, 32'hDEAD_BEEF, 32'd1);
        check_hl("undef_op", 1'b0, h, l);
    endtask

    task automatic test_flush();
        int n;
        issue(3'b100, 32'hAAAA_0000, 32'd0);
        issue(3'b101, 32'h0000_5555, 32'd0);
        issue(3'b011, 32'd1000, 32'd3);
        repeat (9) begin @(posedge clk); #1; end
        bus.Flush = 1'b1;
        @(posedge clk); #1;
        bus.Flush = 1'b0;
        check_hl("flush_div", 1'b0, 32'hAAAA_0000, 32'h0000_5555);
        // flush on the multiply writeback edge
        issue(3'b000, 32'd9, 32'd9);
        bus.Flush = 1'b1;
        @(posedge clk); #1;
        bus.Flush = 1'b0;
        check_hl("flush_mul_wb", 1'b0, 32'hAAAA_0000, 32'h0000_5555);
        // flush on the FIX edge
        issue(3'b010, 32'd50, 32'd5);
        repeat (32) begin @(posedge clk); #1; end
        bus.Flush = 1'b1;
        @(posedge clk); #1;
        bus.Flush = 1'b0;
        check_hl("flush_fix", 1'b0, 32'hAAAA_0000, 32'h0000_5555);
        // flush beats Start, including mthi
        bus.Flush = 1'b1;
        issue(3'b001, 32'd3, 32'd3);
        issue(3'b100, 32'h1234_0000, 32'd0);
        bus.Flush = 1'b0;
        check_hl("flush_start", 1'b0, 32'hAAAA_0000, 32'h0000_5555);
        wait_idle(n);
    endtask

    task automatic test_start_busy();
        int n;
        issue(3'b011, 32'd100, 32'd7);
        repeat (5) begin @(posedge clk); #1; end
        issue(3'b000, 32'd1, 32'd1);
        issue(3'b100, 32'hFFFF_0000, 32'd0);
        wait_idle(n);
        checks++;
        if (n !== 26) begin failures++; $display("FAIL start_busy remaining got=%0d exp=26", n); end
        @(posedge clk); #1;
        check_hl("start_busy", 1'b0, 32'd2, 32'd14);
    endtask

    task automatic test_back_to_back();
        run_op("b2b_mult", 3'b000, 32'd6, 32'hFFFF_FFFB);
        run_op("b2b_div", 3'b010, 32'hFFFF_FF9C, 32'd7);
        run_op("b2b_multu", 3'b001, 32'h0001_0000, 32'h0001_0000);
        issue(3'b101, 32'h0BAD_F00D, 32'd0);
        check_hl("b2b_mtlo", 1'b0, 32'd1, 32'h0BAD_F00D);
    endtask

    task automatic test_async_reset();
        issue(3'b100, 32'h1111_1111, 32'd0);
        issue(3'b010, 32'd12345, 32'd17);
        repeat (5) @(posedge clk);
        #3 rst = 1'b1;
        #1;
        check_hl("async_reset", 1'b0, 32'd0, 32'd0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check_hl("post_reset", 1'b0, 32'd0, 32'd0);
    endtask

    initial begin
        test_reset();
        test_mult();
        test_div();
        test_div_zero();
        test_mthi_mtlo();
        test_flush();
        test_start_busy();
        test_back_to_back();
        test_async_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
